systolic_drain: RTL
===================

# systolic_drain

Result collector at the bottom edge of the systolic array. It receives the accumulator results that each PE column shifts out on its `out_data`/`out_valid` chain. It buffers them per column and re-emits them as a single valid/ready stream in column-major order, tagged with column/row indices and an end-of-tile marker. The PE chain has no backpressure, so this block absorbs bursts and applies the downstream stall only to its own output.

## Interface
- `D_W_ACC`, 64: result width, matches the PE accumulator width.
- `N`, 4: number of array columns; must be ≥ 2.
- `M`, 4: results per column per tile; must be ≥ 2.
- `FIFO_DEPTH`, 16: entries per column FIFO; power of two, ≥ M.

Clocking and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.

- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous clear of FIFOs, counters and state.
- `col_data` in N*D_W_ACC: column c result at bits [c*D_W_ACC +: D_W_ACC].
- `col_valid` in N: per-column valid from the bottom PE.
- `m_data` out D_W_ACC: output result.
- `m_valid` out 1: output valid.
- `m_ready` in 1: downstream ready.
- `m_col` out $clog2(N): column of the current beat.
- `m_row` out $clog2(M): arrival index within the column, 0..M-1.
- `m_last` out 1: last beat of the tile (col N-1, row M-1).
- `err` out 1: sticky overflow flag. Only present as live logic with the macro; see Configuration.

## Operation
- Each column has its own FIFO.
  - When `col_valid[c]` is high, `col_data` slice c is written at the clock edge.
  - Columns are independent and may push in the same cycle.
- Read FSM states:
  - IDLE: exits to DRAIN on the first cycle after reset or flush.
  - DRAIN: holds column counter `cc` (0..N-1) and row counter `rc` (0..M-1).
- In DRAIN, `m_valid` = FIFO[cc] not empty.
  - `m_data` = FIFO[cc] head (first-word fall-through).
  - `m_col` = cc and `m_row` = rc.
- Pop on `m_valid && m_ready`.
  - `rc` increments on each pop.
  - At rc = M-1, `rc` wraps to 0 and `cc` increments.
  - At cc = N-1, `cc` wraps to 0 and the next tile begins.
- `m_last` = (cc == N-1) && (rc == M-1) && `m_valid`.
- An empty FIFO[cc] stalls output even if other columns hold data; there is no reordering.
- Push and pop on the same FIFO in the same cycle are both performed, and the count is unchanged. This holds even when the FIFO is full.
- Overflow is a push to a full FIFO without a same-cycle pop from that FIFO. The word is dropped and the FIFO contents are unchanged.
- `flush` has priority over push and pop.
  - It empties all FIFOs, sets cc = rc = 0, returns the FSM to IDLE and clears `err`.
  - `col_valid` in the flush cycle is ignored.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `m_col` = 0, `m_row` = 0, `m_last` = 0, `err` = 0.
  - All FIFOs empty; FSM in IDLE.
- Latency: a push at edge k into FIFO[cc] makes `m_valid` high in the cycle after edge k. The minimum is one cycle from `col_valid` to output.
- Once `m_valid` is high, `m_valid`, `m_data`, `m_col`, `m_row` and `m_last` hold stable until the beat is accepted (`m_ready` high).
- `m_ready` may be high while `m_valid` is low; this has no effect.
- Throughput: one beat per cycle while FIFO[cc] is non-empty and `m_ready` is high.
- The column switch (rc wrap) adds no bubble. The first beat of cc+1 can follow the last beat of cc on the next cycle.
- Asserting `rst_n` mid-tile discards all buffered data immediately, without waiting for a clock edge.

## Configuration
- `SYSTOLIC_DRAIN_ERR_EN` defined:
  - Overflow detection is built.
  - `err` sets on any column overflow and stays set until `flush` or reset.
- `SYSTOLIC_DRAIN_ERR_EN` undefined:
  - No detection logic is built and `err` is tied to 0.
  - Overflowing pushes are still dropped.

## Test plan
- Burst: N=4, M=4. Each column c pushes 4 words on consecutive cycles starting at cycle c (skewed), data = 16c+r, with `m_ready`=1.
  - Required: 16 beats, data 0,1,2,3,16,...,51 in that order.
  - `m_col`/`m_row` match each beat.
  - `m_last` high only on data 51.
- Backpressure: same stimulus, `m_ready` toggling 1,0,1,0,...
  - Required: identical ordered output.
  - Outputs stable during every ready-low cycle.
  - No drops and `err` = 0.
- Stall on empty column: column 0 pushes 4 words 10 cycles after column 1 finishes.
  - Required: `m_valid` stays 0 until column 0 data arrives.
  - Then column 0 beats are followed by column 1 beats.
- Overflow (macro on), FIFO_DEPTH=16, `m_ready`=0: push 17 words into column 2.
  - Required: `err` = 1 the cycle after the 17th push.
  - After releasing `m_ready`, the 17th word never appears.
- Full with simultaneous push/pop: FIFO[0] full while being drained, with a push in the same cycle.
  - Required: no overflow, `err` = 0, every word delivered in order.
- Flush and reset: mid-tile (after 5 beats) assert `flush` for 1 cycle, then push a fresh tile.
  - Required: output restarts at col 0 row 0 and `err` = 0.
  - Repeat the same sequence with an asynchronous `rst_n` pulse between edges; required: all outputs go to 0 immediately.

Source files
------------

// File: rtl/systolic_drain.sv
// Bottom-edge result collector: per-column FIFOs drained as one column-major valid/ready stream.
// Define SYSTOLIC_DRAIN_ERR_EN to build the sticky overflow flag on err; otherwise err is tied low.
module systolic_drain #(
  parameter int D_W_ACC    = 64,
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N*D_W_ACC-1:0]  col_data,
  input  logic [N-1:0]          col_valid,
  output logic [D_W_ACC-1:0]    m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [$clog2(N)-1:0]  m_col,
  output logic [$clog2(M)-1:0]  m_row,
  output logic                  m_last,
  output logic                  err
);

  localparam int CC_W  = $clog2(N);
  localparam int RC_W  = $clog2(M);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {IDLE, DRAIN} state_e;

  state_e            state_q;
  logic [CC_W-1:0]   cc_q, cc_d;
  logic [RC_W-1:0]   rc_q, rc_d;

  logic [D_W_ACC-1:0] head [N];
  logic [N-1:0]       empty;
  logic [N-1:0]       full;
  logic [N-1:0]       push;
  logic [N-1:0]       pop_col;
  logic               beat_vld;
  logic               pop;

  assign beat_vld = (state_q == DRAIN) && !empty[cc_q];
  assign pop      = beat_vld && m_ready;

  // A full FIFO still accepts a push when the same cycle pops it.
  assign push = col_valid & ~{N{flush}} & (~full | pop_col);

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [D_W_ACC-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q;
    logic [PTR_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cnt_q;

    assign pop_col[c] = pop && (cc_q == CC_W'(c));
    assign empty[c]   = (cnt_q == '0);
    assign full[c]    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign head[c]    = mem_q[rd_q];

    always_ff @(posedge clk) begin
      if (push[c]) begin
        mem_q[wr_q] <= col_data[c*D_W_ACC +: D_W_ACC];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[c]) begin
          wr_q <= wr_q + PTR_W'(1);
        end
        if (pop_col[c]) begin
          rd_q <= rd_q + PTR_W'(1);
        end
        case ({push[c], pop_col[c]})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  always_comb begin
    cc_d = cc_q;
    rc_d = rc_q;
    if (pop) begin
      if (rc_q == RC_W'(M - 1)) begin
        rc_d = '0;
        cc_d = (cc_q == CC_W'(N - 1)) ? '0 : cc_q + CC_W'(1);
      end else begin
        rc_d = rc_q + RC_W'(1);
      end
    end
  end

  // IDLE lasts exactly one cycle after reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cc_q    <= '0;
      rc_q    <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cc_q    <= '0;
      rc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= DRAIN;
        end
        DRAIN: begin
          cc_q <= cc_d;
          rc_q <= rc_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data is gated so the bus reads zero whenever no beat is offered.
  assign m_valid = beat_vld;
  assign m_data  = beat_vld ? head[cc_q] : '0;
  assign m_col   = cc_q;
  assign m_row   = rc_q;
  assign m_last  = beat_vld && (cc_q == CC_W'(N - 1)) && (rc_q == RC_W'(M - 1));

`ifdef SYSTOLIC_DRAIN_ERR_EN
  logic [N-1:0] ovf;
  logic         err_q;

  assign ovf = col_valid & full & ~pop_col & ~{N{flush}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else if (|ovf) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
